// File: rtl/rop_agent_packer.sv
// Splits one warp-wide ROP request into NUM_LANES-wide beats, optionally skipping empty batches.
// Latency 1 cycle accept-to-first-beat; one beat/cycle; in_ready only on the last beat's handshake.
module rop_agent_packer #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int DIM_BITS    = 16,
    parameter int DEPTH_BITS  = 24,
    parameter int UUID_BITS   = 44,
    parameter int NW_BITS     = 2,
    parameter int XLEN        = 32,
    parameter int SKIP_EMPTY  = 1,
    localparam int NB         = NUM_THREADS / NUM_LANES,
    localparam int BB         = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [UUID_BITS-1:0]            in_uuid,
    input  logic [NW_BITS-1:0]              in_wid,
    input  logic [XLEN-1:0]                 in_PC,
    input  logic [NUM_THREADS-1:0]          in_tmask,
    input  logic [NUM_THREADS*DIM_BITS-1:0] in_pos_x,
    input  logic [NUM_THREADS*DIM_BITS-1:0] in_pos_y,
    input  logic [NUM_THREADS-1:0]          in_face,
    input  logic [NUM_THREADS*32-1:0]       in_color,
    input  logic [NUM_THREADS*DEPTH_BITS-1:0] in_depth,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [UUID_BITS-1:0]            out_uuid,
    output logic [NW_BITS-1:0]              out_wid,
    output logic [XLEN-1:0]                 out_PC,
    output logic [BB-1:0]                   out_batch,
    output logic                            out_last,
    output logic [NUM_LANES-1:0]            out_tmask,
    output logic [NUM_LANES*DIM_BITS-1:0]   out_pos_x,
    output logic [NUM_LANES*DIM_BITS-1:0]   out_pos_y,
    output logic [NUM_LANES-1:0]            out_face,
    output logic [NUM_LANES*32-1:0]         out_color,
    output logic [NUM_LANES*DEPTH_BITS-1:0] out_depth,
    output logic [31:0]                     perf_beats
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t  state_q, state_d;
    logic [BB-1:0] cur_q, cur_d;
    logic [31:0]   perf_q;

    logic [UUID_BITS-1:0]              uuid_q;
    logic [NW_BITS-1:0]                wid_q;
    logic [XLEN-1:0]                   pc_q;
    logic [NUM_THREADS-1:0]            tmask_q;
    logic [NUM_THREADS*DIM_BITS-1:0]   posx_q;
    logic [NUM_THREADS*DIM_BITS-1:0]   posy_q;
    logic [NUM_THREADS-1:0]            face_q;
    logic [NUM_THREADS*32-1:0]         color_q;
    logic [NUM_THREADS*DEPTH_BITS-1:0] depth_q;

    logic [NB-1:0] vmask_in, vmask_q;
    logic [BB-1:0] first_idx, nxt_idx;
    logic          nxt_found;
    logic          accept;

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            vmask_in[b] = (SKIP_EMPTY != 0) ? |in_tmask[b*NUM_LANES +: NUM_LANES] : 1'b1;
            vmask_q[b]  = (SKIP_EMPTY != 0) ? |tmask_q[b*NUM_LANES +: NUM_LANES]  : 1'b1;
        end
    end

    // Descending scans so the lowest qualifying batch wins.
    always_comb begin
        first_idx = '0;
        nxt_idx   = '0;
        nxt_found = 1'b0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (vmask_in[b]) begin
                first_idx = BB'(b);
            end
            if (vmask_q[b] && (b > int'(cur_q))) begin
                nxt_idx   = BB'(b);
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        out_valid = 1'b0;
        in_ready  = 1'b1;
        if (state_q == SEND) begin
            out_valid = 1'b1;
            in_ready  = out_ready && !nxt_found;
            if (out_ready) begin
                if (nxt_found) begin
                    cur_d = nxt_idx;
                end else begin
                    state_d = IDLE;
                end
            end
        end
        accept = in_valid && in_ready;
        // An all-empty request is swallowed without producing any beat.
        if (accept) begin
            if (|vmask_in) begin
                state_d = SEND;
                cur_d   = first_idx;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            if (out_valid && out_ready) begin
                perf_q <= perf_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            uuid_q  <= in_uuid;
            wid_q   <= in_wid;
            pc_q    <= in_PC;
            tmask_q <= in_tmask;
            posx_q  <= in_pos_x;
            posy_q  <= in_pos_y;
            face_q  <= in_face;
            color_q <= in_color;
            depth_q <= in_depth;
        end
    end

    assign out_uuid   = uuid_q;
    assign out_wid    = wid_q;
    assign out_PC     = pc_q;
    assign out_batch  = cur_q;
    assign out_last   = !nxt_found;
    assign out_tmask  = tmask_q[int'(cur_q)*NUM_LANES +: NUM_LANES];
    assign out_face   = face_q[int'(cur_q)*NUM_LANES +: NUM_LANES];
    assign out_pos_x  = posx_q[int'(cur_q)*NUM_LANES*DIM_BITS +: NUM_LANES*DIM_BITS];
    assign out_pos_y  = posy_q[int'(cur_q)*NUM_LANES*DIM_BITS +: NUM_LANES*DIM_BITS];
    assign out_color  = color_q[int'(cur_q)*NUM_LANES*32 +: NUM_LANES*32];
    assign out_depth  = depth_q[int'(cur_q)*NUM_LANES*DEPTH_BITS +: NUM_LANES*DEPTH_BITS];
    assign perf_beats = perf_q;

endmodule

// File: tb/tb_rop_agent_packer.sv
// Directed bench for rop_agent_packer: scoreboard of expected beats, one DUT per SKIP_EMPTY setting.
// Beats are popped and compared whenever a handshake is seen at the falling edge.
module tb_rop_agent_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [43:0]  uuid;
        logic [1:0]   wid;
        logic [31:0]  pc;
        logic [3:0]   tmask;
        logic [63:0]  px;
        logic [63:0]  py;
        logic [3:0]   face;
        logic [127:0] color;
        logic [95:0]  depth;
    } req_t;

    typedef struct packed {
        logic [0:0]  batch;
        logic        last;
        logic [43:0] uuid;
        logic [1:0]  wid;
        logic [31:0] pc;
        logic [1:0]  tmask;
        logic [31:0] px;
        logic [31:0] py;
        logic [1:0]  face;
        logic [63:0] color;
        logic [47:0] depth;
    } beat_t;

    logic reset, in_valid, in_valid0, in_ready, in_ready0, out_ready;
    logic [43:0] in_uuid;
    logic [1:0]  in_wid;
    logic [31:0] in_PC;
    logic [3:0]  in_tmask, in_face;
    logic [63:0] in_pos_x, in_pos_y;
    logic [127:0] in_color;
    logic [95:0]  in_depth;

    logic out_valid, out_last, out_valid0, out_last0;
    logic [0:0]  out_batch, out_batch0;
    logic [43:0] out_uuid, out_uuid0;
    logic [1:0]  out_wid, out_wid0, out_tmask, out_tmask0, out_face, out_face0;
    logic [31:0] out_PC, out_PC0, out_pos_x, out_pos_x0, out_pos_y, out_pos_y0;
    logic [63:0] out_color, out_color0;
    logic [47:0] out_depth, out_depth0;
    logic [31:0] perf_beats, perf_beats0;

    rop_agent_packer #(.SKIP_EMPTY(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_uuid(in_uuid), .in_wid(in_wid), .in_PC(in_PC), .in_tmask(in_tmask),
        .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_face(in_face),
        .in_color(in_color), .in_depth(in_depth),
        .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid),
        .out_wid(out_wid), .out_PC(out_PC), .out_batch(out_batch), .out_last(out_last),
        .out_tmask(out_tmask), .out_pos_x(out_pos_x), .out_pos_y(out_pos_y),
        .out_face(out_face), .out_color(out_color), .out_depth(out_depth),
        .perf_beats(perf_beats)
    );

    rop_agent_packer #(.SKIP_EMPTY(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_uuid(in_uuid), .in_wid(in_wid), .in_PC(in_PC), .in_tmask(in_tmask),
        .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_face(in_face),
        .in_color(in_color), .in_depth(in_depth),
        .out_valid(out_valid0), .out_ready(1'b1), .out_uuid(out_uuid0),
        .out_wid(out_wid0), .out_PC(out_PC0), .out_batch(out_batch0), .out_last(out_last0),
        .out_tmask(out_tmask0), .out_pos_x(out_pos_x0), .out_pos_y(out_pos_y0),
        .out_face(out_face0), .out_color(out_color0), .out_depth(out_depth0),
        .perf_beats(perf_beats0)
    );

    beat_t q1[$];
    beat_t q0[$];
    int    tests = 0;
    int    fails = 0;
    int    perf_exp = 0;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mkreq(input logic [3:0] tm);
        req_t r;
        r.uuid  = {12'($urandom), $urandom};
        r.wid   = 2'($urandom);
        r.pc    = $urandom;
        r.tmask = tm;
        r.px    = {$urandom, $urandom};
        r.py    = {$urandom, $urandom};
        r.face  = 4'($urandom);
        r.color = {$urandom, $urandom, $urandom, $urandom};
        r.depth = {$urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic beat_t slice(input req_t r, input int b, input logic last);
        beat_t e;
        e.batch = 1'(b);
        e.last  = last;
        e.uuid  = r.uuid;
        e.wid   = r.wid;
        e.pc    = r.pc;
        e.tmask = r.tmask[b*2 +: 2];
        e.px    = r.px[b*32 +: 32];
        e.py    = r.py[b*32 +: 32];
        e.face  = r.face[b*2 +: 2];
        e.color = r.color[b*64 +: 64];
        e.depth = r.depth[b*48 +: 48];
        return e;
    endfunction

    task automatic drive(input req_t r);
        in_uuid  = r.uuid;
        in_wid   = r.wid;
        in_PC    = r.pc;
        in_tmask = r.tmask;
        in_pos_x = r.px;
        in_pos_y = r.py;
        in_face  = r.face;
        in_color = r.color;
        in_depth = r.depth;
    endtask

    // Expected beats: every batch with a live lane (or every batch when not skipping).
    task automatic push_exp(input req_t r, input bit skip, input bit to_q0);
        logic [1:0] vm;
        vm[0] = skip ? |r.tmask[1:0] : 1'b1;
        vm[1] = skip ? |r.tmask[3:2] : 1'b1;
        for (int b = 0; b < 2; b++) begin
            if (vm[b]) begin
                if (to_q0) q0.push_back(slice(r, b, !(b == 0 && vm[1])));
                else begin
                    q1.push_back(slice(r, b, !(b == 0 && vm[1])));
                    perf_exp++;
                end
            end
        end
    endtask

    task automatic tick();
        beat_t obs;
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            obs = {out_batch, out_last, out_uuid, out_wid, out_PC, out_tmask,
                   out_pos_x, out_pos_y, out_face, out_color, out_depth};
            chk("beat_expected", 320'(q1.size() != 0), 320'(1));
            if (q1.size() != 0) chk("beat", 320'(obs), 320'(q1.pop_front()));
        end
        if (!reset && out_valid0) begin
            obs = {out_batch0, out_last0, out_uuid0, out_wid0, out_PC0, out_tmask0,
                   out_pos_x0, out_pos_y0, out_face0, out_color0, out_depth0};
            chk("beat0_expected", 320'(q0.size() != 0), 320'(1));
            if (q0.size() != 0) chk("beat0", 320'(obs), 320'(q0.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_done", 320'(q1.size() + q0.size()), 320'(0));
    endtask

    initial begin
        req_t ra, rb;
        beat_t cur;
        reset = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1;
        drive(mkreq(4'h0));
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 320'(out_valid), 320'(0));
        chk("rst_in_ready", 320'(in_ready), 320'(1));
        chk("rst_perf", 320'(perf_beats), 320'(0));

        // Partial mask 0110: two beats, one lane each.
        ra = mkreq(4'b0110);
        drive(ra); in_valid = 1'b1; push_exp(ra, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("lat_out_valid", 320'(out_valid), 320'(1));
        drain(10);
        chk("t1_perf", 320'(perf_beats), 320'(perf_exp));
        chk("t1_idle", 320'(out_valid), 320'(0));

        // Mask 1100: one beat skipping; two beats without skipping.
        ra = mkreq(4'b1100);
        drive(ra); in_valid = 1'b1; in_valid0 = 1'b1;
        push_exp(ra, 1'b1, 1'b0); push_exp(ra, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0; in_valid0 = 1'b0;
        chk("t2_batch", 320'(out_batch), 320'(1));
        chk("t2_last", 320'(out_last), 320'(1));
        drain(10);
        chk("t2_perf", 320'(perf_beats), 320'(perf_exp));
        chk("t2_perf0", 320'(perf_beats0), 320'(2));

        // Empty mask: consumed and dropped.
        ra = mkreq(4'b0000);
        chk("t3_in_ready", 320'(in_ready), 320'(1));
        drive(ra); in_valid = 1'b1; push_exp(ra, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_no_valid", 320'(out_valid), 320'(0));
            tick();
        end
        chk("t3_perf", 320'(perf_beats), 320'(perf_exp));

        // Back-to-back A then B with in_valid held high.
        ra = mkreq(4'b1111);
        drive(ra); in_valid = 1'b1; push_exp(ra, 1'b1, 1'b0);
        tick();
        rb = mkreq(4'b0011);
        drive(rb); push_exp(rb, 1'b1, 1'b0);
        chk("t4_b0_in_ready", 320'(in_ready), 320'(0));
        chk("t4_b0_last", 320'(out_last), 320'(0));
        tick();
        chk("t4_b1_in_ready", 320'(in_ready), 320'(1));
        chk("t4_b1_last", 320'(out_last), 320'(1));
        tick();
        in_valid = 1'b0;
        chk("t4_no_bubble", 320'(out_valid), 320'(1));
        chk("t4_b_batch", 320'(out_batch), 320'(0));
        drain(10);
        chk("t4_idle", 320'(out_valid), 320'(0));
        chk("t4_perf", 320'(perf_beats), 320'(perf_exp));

        // Backpressure: payload holds while out_ready is low.
        ra = mkreq(4'b1111);
        drive(ra); in_valid = 1'b1; out_ready = 1'b0; push_exp(ra, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        drive(mkreq(4'b1010));
        for (int i = 0; i < 5; i++) begin
            cur = {out_batch, out_last, out_uuid, out_wid, out_PC, out_tmask,
                   out_pos_x, out_pos_y, out_face, out_color, out_depth};
            chk("t5_valid", 320'(out_valid), 320'(1));
            chk("t5_in_ready", 320'(in_ready), 320'(0));
            chk("t5_stable", 320'(cur), 320'(q1[0]));
            tick();
        end
        out_ready = 1'b1;
        drain(10);
        chk("t5_perf", 320'(perf_beats), 320'(perf_exp));

        // Reset after the first beat drops the rest.
        ra = mkreq(4'b1111);
        drive(ra); in_valid = 1'b1; push_exp(ra, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6_second_beat", 320'(out_batch), 320'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q1.delete();
        perf_exp = 0;
        #1;
        chk("t6_out_valid", 320'(out_valid), 320'(0));
        chk("t6_in_ready", 320'(in_ready), 320'(1));
        chk("t6_perf", 320'(perf_beats), 320'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_quiet", 320'(out_valid), 320'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
